// File: rtl/touch_spi_responder.sv
// Touch-controller (ADS7843-style) SPI responder emulation.
// Clock/reset : MAX10_CLK1_50 (rising edge), rst_n (async, active-low)
// SPI side    : t_sck, t_cs (active-low), t_sdi in; t_sdo, t_irq (active-low) out
// Emulation   : x_value, y_value (12-bit results), pressed (pen-down) in
// Status      : last_cmd (last complete control byte), cmd_valid (1-clock pulse)
module touch_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        MAX10_CLK1_50,
  input  logic        rst_n,
  input  logic        t_sck,
  input  logic        t_cs,
  input  logic        t_sdi,
  output logic        t_sdo,
  output logic        t_irq,
  input  logic [11:0] x_value,
  input  logic [11:0] y_value,
  input  logic        pressed,
  output logic [7:0]  last_cmd,
  output logic        cmd_valid
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned CMD_W  = 8;

  typedef enum logic [2:0] {IDLE, HUNT, CMD, DATA, TAIL} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sdi_sync;
  logic sck_q, cs_q;
  logic sck_s, cs_s, sdi_s;
  logic sck_rise_c, sck_fall_c, cs_rise_c, cs_fall_c;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CMD_W-2:0]   cmd_sr, cmd_nxt;
  logic [DATA_W-1:0]  data_sr, data_nxt;
  logic               sdo_nxt, irq_nxt, valid_nxt;
  logic [CMD_W-1:0]   last_nxt;
  logic [CMD_W-1:0]   byte_c;
  logic [DATA_W-1:0]  sel_c;

  // Input synchronizers; reset to 0 so a t_cs held low through reset
  // produces no falling edge afterwards.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync <= '0;
      cs_sync  <= '0;
      sdi_sync <= '0;
      sck_q    <= 1'b0;
      cs_q     <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], t_sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], t_cs};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], t_sdi};
      sck_q    <= sck_s;
      cs_q     <= cs_s;
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync[SYNC_STAGES-1];
  assign sck_rise_c = sck_s & ~sck_q;
  assign sck_fall_c = ~sck_s & sck_q;
  assign cs_rise_c  = cs_s & ~cs_q;
  assign cs_fall_c  = ~cs_s & cs_q;

  // Control byte as it would look after the current bit is shifted in.
  assign byte_c = {cmd_sr, sdi_s};

  // Conversion result selection; 8-bit mode zeroes the low nibble so the
  // shifter naturally emits 0 after D4.
  always_comb begin
    sel_c = '0;
    case (byte_c[6:4])
      3'b101:  sel_c = x_value;
      3'b001:  sel_c = y_value;
      default: sel_c = '0;
    endcase
    if (byte_c[3]) sel_c[3:0] = 4'h0;
  end

  // State and output registers.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_sr    <= '0;
      data_sr   <= '0;
      t_sdo     <= 1'b0;
      t_irq     <= 1'b1;
      last_cmd  <= '0;
      cmd_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd_sr    <= cmd_nxt;
      data_sr   <= data_nxt;
      t_sdo     <= sdo_nxt;
      t_irq     <= irq_nxt;
      last_cmd  <= last_nxt;
      cmd_valid <= valid_nxt;
    end
  end

  // Next-state and output logic; cnt counts rising edges from the start bit,
  // so on a falling edge it equals that falling edge's index.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmd_nxt   = cmd_sr;
    data_nxt  = data_sr;
    sdo_nxt   = t_sdo;
    last_nxt  = last_cmd;
    valid_nxt = 1'b0;

    if (cs_rise_c) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      cmd_nxt   = '0;
      data_nxt  = '0;
      sdo_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall_c) begin
            state_nxt = HUNT;
            cnt_nxt   = '0;
            cmd_nxt   = '0;
          end
        end
        HUNT: begin
          if (sck_rise_c && sdi_s) begin
            state_nxt = CMD;
            cnt_nxt   = CNT_W'(1);
            cmd_nxt   = (CMD_W-1)'(1);
          end
        end
        CMD: begin
          if (sck_rise_c) begin
            cnt_nxt = cnt + CNT_W'(1);
            cmd_nxt = byte_c[CMD_W-2:0];
            if (cnt == CNT_W'(7)) begin
              state_nxt = DATA;
              last_nxt  = byte_c;
              valid_nxt = 1'b1;
              data_nxt  = sel_c;
            end
          end
        end
        DATA: begin
          if (sck_rise_c) begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(20)) state_nxt = TAIL;
          end else if (sck_fall_c) begin
            if (cnt == CNT_W'(8)) begin
              sdo_nxt = 1'b0;
            end else begin
              sdo_nxt  = data_sr[DATA_W-1];
              data_nxt = {data_sr[DATA_W-2:0], 1'b0};
            end
          end
        end
        TAIL: begin
          if (sck_rise_c) begin
            if (cnt == CNT_W'(23)) begin
              state_nxt = HUNT;
              cnt_nxt   = '0;
              cmd_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else if (sck_fall_c) begin
            sdo_nxt = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Pen IRQ is masked while a conversion frame is in progress.
    irq_nxt = ((state_nxt == IDLE) || (state_nxt == HUNT)) ? ~pressed : 1'b1;
  end

endmodule

// File: tb/tb_touch_spi_responder.sv
// Directed bench for touch_spi_responder: table of single-frame vectors plus
// hand-written sequences for aborts, back-to-back frames, IRQ and reset.
module tb_touch_spi_responder;

  localparam int HALF = 8;  // SCK half period in system clocks (SCK = clk/16)

  logic        clk = 1'b0;
  logic        rst_n;
  logic        t_sck, t_cs, t_sdi;
  logic        t_sdo, t_irq;
  logic [11:0] x_value, y_value;
  logic        pressed;
  logic [7:0]  last_cmd;
  logic        cmd_valid;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  touch_spi_responder #(.SYNC_STAGES(2)) dut (
    .MAX10_CLK1_50(clk),
    .rst_n(rst_n),
    .t_sck(t_sck),
    .t_cs(t_cs),
    .t_sdi(t_sdi),
    .t_sdo(t_sdo),
    .t_irq(t_irq),
    .x_value(x_value),
    .y_value(y_value),
    .pressed(pressed),
    .last_cmd(last_cmd),
    .cmd_valid(cmd_valid)
  );

  always #10 clk = ~clk;

  // Counts clocks with cmd_valid high, so a stretched pulse shows up as extra.
  always @(negedge clk) if (cmd_valid === 1'b1) valid_cnt++;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  cmd;
    int          lead;
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  exp_last;
    logic [11:0] exp_word;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period: drive DIN, sample DOUT just before the rising edge.
  task automatic sck_bit(input logic b, output logic s);
    t_sdi = b;
    clks(HALF);
    s = t_sdo;
    t_sck = 1'b1;
    clks(HALF);
    t_sck = 1'b0;
  endtask

  // Leading zeros, then a 24-clock frame; bits[24-k] is DOUT seen before rise k.
  task automatic frame(input logic [7:0] cmd, input int lead, input bit swap,
                       output logic [23:0] bits);
    logic s;
    logic b;
    for (int i = 0; i < lead; i++) sck_bit(1'b0, s);
    for (int k = 1; k <= 24; k++) begin
      b = (k <= 8) ? cmd[8-k] : 1'b0;
      sck_bit(b, s);
      bits[24-k] = s;
      if (k == 8 && swap) begin
        x_value = ~x_value;
        y_value = ~y_value;
      end
    end
  endtask

  initial begin
    logic [23:0] bits, bits2;
    logic        s;
    int          v0;
    logic [7:0]  d0;

    vecs[0] = '{8'hD0, 0, 12'hABC, 12'h123, 8'hD0, 12'hABC};
    vecs[1] = '{8'h98, 0, 12'hABC, 12'h123, 8'h98, 12'h120};
    vecs[2] = '{8'h90, 3, 12'hABC, 12'h123, 8'h90, 12'h123};
    vecs[3] = '{8'hA0, 1, 12'hABC, 12'h123, 8'hA0, 12'h000};
    vecs[4] = '{8'hD8, 0, 12'h5A5, 12'h123, 8'hD8, 12'h5A0};
    vecs[5] = '{8'h94, 0, 12'h5A5, 12'h0FE, 8'h94, 12'h0FE};
    vecs[6] = '{8'h9C, 0, 12'h5A5, 12'h0FE, 8'h9C, 12'h0F0};
    d0 = 8'hD0;

    rst_n = 1'b0; t_sck = 1'b0; t_cs = 1'b1; t_sdi = 1'b0;
    x_value = 12'h000; y_value = 12'h000; pressed = 1'b0;

    // Reset values
    clks(3);
    check("rst sdo", 32'(t_sdo), 32'd0);
    check("rst irq", 32'(t_irq), 32'd1);
    check("rst last_cmd", 32'(last_cmd), 32'h00);
    check("rst cmd_valid", 32'(cmd_valid), 32'd0);
    rst_n = 1'b1;
    clks(HALF);

    // Table-driven single frames
    for (int i = 0; i < 7; i++) begin
      x_value = vecs[i].x;
      y_value = vecs[i].y;
      v0 = valid_cnt;
      t_cs = 1'b0;
      clks(HALF);
      frame(vecs[i].cmd, vecs[i].lead, 1'b1, bits);
      clks(HALF);
      check($sformatf("vec%0d valid", i), 32'(valid_cnt - v0), 32'd1);
      check($sformatf("vec%0d last_cmd", i), 32'(last_cmd), 32'(vecs[i].exp_last));
      check($sformatf("vec%0d dout", i), 32'(bits), 32'({9'b0, vecs[i].exp_word, 3'b0}));
      t_cs = 1'b1;
      clks(HALF);
    end

    // Abort after 5 command bits, then a clean frame
    x_value = 12'hABC; y_value = 12'h123;
    v0 = valid_cnt;
    t_cs = 1'b0;
    clks(HALF);
    for (int k = 1; k <= 5; k++) sck_bit(d0[8-k], s);
    clks(HALF);
    t_cs = 1'b1;
    clks(HALF);
    check("abort5 valid", 32'(valid_cnt - v0), 32'd0);
    check("abort5 sdo", 32'(t_sdo), 32'd0);
    check("abort5 last_cmd", 32'(last_cmd), 32'h9C);
    t_cs = 1'b0;
    clks(HALF);
    frame(8'hD0, 0, 1'b0, bits);
    clks(HALF);
    check("after abort valid", 32'(valid_cnt - v0), 32'd1);
    check("after abort last_cmd", 32'(last_cmd), 32'hD0);
    check("after abort dout", 32'(bits), 32'({9'b0, 12'hABC, 3'b0}));
    t_cs = 1'b1;
    clks(HALF);

    // Abort mid-DATA while DOUT is high
    t_cs = 1'b0;
    clks(HALF);
    for (int k = 1; k <= 9; k++) sck_bit((k <= 8) ? d0[8-k] : 1'b0, s);
    clks(4);
    check("data D11 high", 32'(t_sdo), 32'd1);
    t_cs = 1'b1;
    clks(6);
    check("data abort sdo", 32'(t_sdo), 32'd0);
    clks(HALF);

    // Back-to-back frames with t_cs held low
    v0 = valid_cnt;
    t_cs = 1'b0;
    clks(HALF);
    frame(8'hD0, 0, 1'b0, bits);
    frame(8'h90, 0, 1'b0, bits2);
    clks(HALF);
    check("b2b valid", 32'(valid_cnt - v0), 32'd2);
    check("b2b x dout", 32'(bits), 32'({9'b0, 12'hABC, 3'b0}));
    check("b2b y dout", 32'(bits2), 32'({9'b0, 12'h123, 3'b0}));
    check("b2b last_cmd", 32'(last_cmd), 32'h90);
    t_cs = 1'b1;
    clks(HALF);

    // t_cs rises on the same clock as the 8th rising edge
    v0 = valid_cnt;
    t_cs = 1'b0;
    clks(HALF);
    for (int k = 1; k <= 7; k++) sck_bit(d0[8-k], s);
    t_sdi = 1'b0;
    clks(HALF);
    t_sck = 1'b1;
    t_cs = 1'b1;
    clks(HALF);
    t_sck = 1'b0;
    clks(HALF);
    check("tie valid", 32'(valid_cnt - v0), 32'd0);
    check("tie last_cmd", 32'(last_cmd), 32'h90);
    check("tie sdo", 32'(t_sdo), 32'd0);

    // Pen IRQ and reset mid-DATA
    pressed = 1'b1;
    clks(6);
    check("irq idle", 32'(t_irq), 32'd0);
    t_cs = 1'b0;
    clks(HALF);
    check("irq hunt", 32'(t_irq), 32'd0);
    sck_bit(1'b1, s);
    check("irq frame", 32'(t_irq), 32'd1);
    for (int k = 2; k <= 11; k++) sck_bit((k <= 8) ? d0[8-k] : 1'b0, s);
    clks(4);
    check("irq data", 32'(t_irq), 32'd1);
    check("data D9 high", 32'(t_sdo), 32'd1);
    rst_n = 1'b0;
    clks(2);
    check("midrst sdo", 32'(t_sdo), 32'd0);
    check("midrst irq", 32'(t_irq), 32'd1);
    check("midrst last_cmd", 32'(last_cmd), 32'h00);
    check("midrst cmd_valid", 32'(cmd_valid), 32'd0);

    // Release with t_cs still low: no HUNT until a fresh falling edge
    pressed = 1'b0;
    clks(2);
    rst_n = 1'b1;
    clks(HALF);
    v0 = valid_cnt;
    frame(8'hD0, 0, 1'b0, bits);
    clks(HALF);
    check("heldcs valid", 32'(valid_cnt - v0), 32'd0);
    check("heldcs last_cmd", 32'(last_cmd), 32'h00);
    check("heldcs dout", 32'(bits), 32'd0);
    t_cs = 1'b1;
    clks(HALF);
    t_cs = 1'b0;
    clks(HALF);
    frame(8'hD0, 0, 1'b0, bits);
    clks(HALF);
    check("recover valid", 32'(valid_cnt - v0), 32'd1);
    check("recover last_cmd", 32'(last_cmd), 32'hD0);
    check("recover dout", 32'(bits), 32'({9'b0, 12'hABC, 3'b0}));
    t_cs = 1'b1;
    clks(HALF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/touch_spi_responder.md
TOUCH_SPI_RESPONDER -- requirements
Module: touch_spi_responder

Interface
REQ-001 The parameter SHALL be SYNC_STAGES, default 2, the depth of the synchronizer on t_sck, t_cs and t_sdi (legal range 2-3).
REQ-002 The port MAX10_CLK1_50 SHALL be an input of width 1 and the sole clock; all logic SHALL be on its rising edge.
REQ-003 The port rst_n SHALL be an input of width 1; reset SHALL be asynchronous and active-low.
REQ-004 The port t_sck SHALL be an input of width 1: SPI clock from the touch initiator, idle low.
REQ-005 The port t_cs SHALL be an input of width 1: chip select from the initiator, active-low.
REQ-006 The port t_sdi SHALL be an input of width 1: initiator-to-responder serial data (DIN).
REQ-007 The port t_sdo SHALL be an output of width 1: responder-to-initiator serial data (DOUT).
REQ-008 The port t_irq SHALL be an output of width 1: pen interrupt, active-low.
REQ-009 The ports x_value and y_value SHALL be inputs of width 12: emulated conversion results.
REQ-010 The port pressed SHALL be an input of width 1: emulated pen-down.
REQ-011 The port last_cmd SHALL be an output of width 8: the most recent complete control byte.
REQ-012 The port cmd_valid SHALL be an output of width 1: a one-clock pulse when last_cmd updates.

Function
REQ-013 t_sck, t_cs and t_sdi SHALL each pass through a SYNC_STAGES flop synchronizer; edges SHALL be detected on the synchronized t_sck.
REQ-014 The design SHALL operate correctly for t_sck frequencies up to MAX10_CLK1_50/8.
REQ-015 The state machine SHALL have the states IDLE (t_cs high), HUNT (waiting for start bit), CMD (shifting bits 6:0), DATA (shifting result) and TAIL (idle bits to frame end).
REQ-016 In HUNT, t_sdi SHALL be sampled on each rising t_sck; a 0 SHALL keep HUNT, and a 1 (start bit) SHALL enter CMD with rise count 1.
REQ-017 In CMD, bits SHALL be shifted MSB-first on rising edges; the 8th rising edge SHALL complete the control byte.
REQ-018 On completion, last_cmd SHALL load the byte, cmd_valid SHALL pulse for one clock, and the result register SHALL latch as follows:
- channel bits [6:4]=101 -> x_value;
- channel bits [6:4]=001 -> y_value;
- any other channel -> 12'h000.
REQ-019 x_value/y_value changes after the latch point SHALL NOT affect the word being shifted.
REQ-020 t_sdo SHALL change only on falling t_sck.
- falling edge 8: 0 (busy bit);
- falling edges 9-20: D11..D0 when cmd bit3 (MODE)=0;
- falling edges 9-16: D11..D4 when MODE=1, then 0;
- all later falling edges: 0.
REQ-021 t_sdo SHALL update within SYNC_STAGES+2 clocks of the raw falling t_sck edge.
REQ-022 After the 24th rising edge counted from the start bit, the FSM SHALL return to HUNT without t_cs deasserting (back-to-back 24-clock conversions).
REQ-023 t_cs rising at any point SHALL abort to IDLE, clear the counters and drive t_sdo 0; cmd_valid SHALL NOT pulse for a byte with fewer than 8 bits.
REQ-024 t_cs falling SHALL enter HUNT with the bit counter at 0.
REQ-025 t_irq SHALL be registered, equal to ~pressed in IDLE/HUNT, and held at 1 in CMD/DATA/TAIL (pen IRQ disabled during conversion).
REQ-026 If t_cs rises on the same clock as the 8th rising edge, the abort SHALL take priority and no cmd_valid SHALL occur.

Reset
REQ-027 On rst_n low, the FSM SHALL be IDLE, all counters and shift registers 0, t_sdo=0, t_irq=1, last_cmd=8'h00 and cmd_valid=0.
REQ-028 Reset mid-frame SHALL abort immediately; after release, the FSM SHALL wait for a t_cs falling edge before HUNT (a held-low t_cs SHALL NOT re-enter HUNT).

Verification
REQ-029 x_value=12'hABC, t_cs low, send 8'hD0 then 16 clocks -> cmd_valid pulse, last_cmd=8'hD0, t_sdo bits after falling 8..20 = 0,1010_1011_1100, then 0.
REQ-030 y_value=12'h123, send 8'h98 (MODE=1) -> data bits 0001_0010, then 0s.
REQ-031 Send three 0 bits then 8'h90 -> leading zeros ignored, last_cmd=8'h90, y_value returned.
REQ-032 Raise t_cs after 5 command bits -> no cmd_valid, t_sdo=0, next frame with 8'hD0 decodes correctly.
REQ-033 Two back-to-back 24-clock frames (8'hD0, 8'h90) with t_cs held low -> two cmd_valid pulses, X then Y data.
REQ-034 pressed=1 while idle -> t_irq=0; during the frame t_irq=1; assert rst_n low mid-DATA -> t_sdo=0, t_irq=1, last_cmd=8'h00.
